// File: rtl/sdram_pkg.sv
// sdram_pkg: SDRAM command encodings, controller FSM states, field indices.
// Shared by the init/refresh sequencer and its refresh timer.
package sdram_pkg;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_INHIBIT = 4'b1111;
  localparam logic [3:0] CMD_NOP     = 4'b0111;
  localparam logic [3:0] CMD_PRE     = 4'b0010;
  localparam logic [3:0] CMD_REF     = 4'b0001;
  localparam logic [3:0] CMD_MRS     = 4'b0000;

  localparam int A10 = 10;
  localparam int WCNT_W = 15;

  localparam int PEND_W = 4;
  localparam logic [PEND_W-1:0] PEND_MAX = 4'd8;

  typedef enum logic [3:0] {
    S_PWRUP,
    S_PRE,
    S_WAIT_RP,
    S_IREF,
    S_WAIT_RFC,
    S_MRS,
    S_WAIT_MRD,
    S_IDLE,
    S_RPRE,
    S_RWAIT_RP,
    S_RREF,
    S_RWAIT_RFC
  } state_e;

  function automatic logic [12:0] pre_all_addr();
    logic [12:0] a;
    a = '0;
    a[A10] = 1'b1;
    return a;
  endfunction

endpackage

// File: rtl/sdram_refresh_timer.sv
// sdram_refresh_timer: refresh interval counter plus pending-refresh counter.
// Ports: sys_clk, rst_n; run_i enables the interval counter; issue_i marks an
//   AUTO REFRESH on the bus; pend_nz_o = refreshes owed; overflow_o sticky.
module sdram_refresh_timer
  import sdram_pkg::*;
#(
  parameter int REF_INTERVAL = 780
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic run_i,
  input  logic issue_i,
  output logic pend_nz_o,
  output logic overflow_o
);

  localparam int IW = $clog2(REF_INTERVAL + 1);
  localparam logic [IW-1:0] RELOAD = IW'(REF_INTERVAL - 1);

  logic [IW-1:0]     ivl_q, ivl_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              ovf_q, ovf_d;
  logic              tick;

  assign tick = run_i && (ivl_q == '0);

  // A tick and an issue in the same cycle cancel out.
  always_comb begin
    ivl_d  = ivl_q;
    pend_d = pend_q;
    ovf_d  = ovf_q;
    if (run_i) begin
      ivl_d = tick ? RELOAD : ivl_q - 1'b1;
    end
    if (tick && !issue_i) begin
      if (pend_q == PEND_MAX) begin
        ovf_d = 1'b1;
      end else begin
        pend_d = pend_q + 1'b1;
      end
    end else if (issue_i && !tick && pend_q != '0) begin
      pend_d = pend_q - 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      ivl_q  <= RELOAD;
      pend_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      ivl_q  <= ivl_d;
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
    end
  end

  assign pend_nz_o  = (pend_q != '0);
  assign overflow_o = ovf_q;

endmodule

// File: rtl/sdram_init_refresh.sv
// sdram_init_refresh: SDRAM power-up sequence then arbitrated periodic refresh.
// Ports: sys_clk, rst_n, ref_ack in; sdr_cke/cmd/addr/ba command bus, bus_own,
//   init_done, ref_req, ref_done, ref_overflow out. All outputs registered.
module sdram_init_refresh
  import sdram_pkg::*;
#(
  parameter int          PWRUP_CYC    = 20000,
  parameter int          T_RP         = 2,
  parameter int          T_RFC        = 7,
  parameter int          T_MRD        = 2,
  parameter int          INIT_REFS    = 8,
  parameter int          REF_INTERVAL = 780,
  parameter logic [12:0] MODE_REG     = 13'h032
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        ref_ack,
  output logic        sdr_cke,
  output logic [3:0]  sdr_cmd,
  output logic [12:0] sdr_addr,
  output logic [1:0]  sdr_ba,
  output logic        bus_own,
  output logic        init_done,
  output logic        ref_req,
  output logic        ref_done,
  output logic        ref_overflow
);

  // Wait states last T-1 cycles; the next command lands on cycle T.
  localparam logic [WCNT_W-1:0] PWRUP_LIM = WCNT_W'(PWRUP_CYC);
  localparam logic [WCNT_W-1:0] RP_LD     = WCNT_W'(T_RP - 2);
  localparam logic [WCNT_W-1:0] RFC_LD    = WCNT_W'(T_RFC - 2);
  localparam logic [WCNT_W-1:0] MRD_LD    = WCNT_W'(T_MRD - 2);

  localparam int IRW = $clog2(INIT_REFS + 1);
  localparam logic [IRW-1:0] IREF_N = IRW'(INIT_REFS);

  state_e            state_q;
  logic [WCNT_W-1:0] cnt_q;
  logic [IRW-1:0]    iref_q;

  logic        cke_q;
  logic [3:0]  cmd_q;
  logic [12:0] addr_q;
  logic [1:0]  ba_q;
  logic        own_q;
  logic        done_q;
  logic        req_q;
  logic        rdone_q;

  logic ref_issue;
  logic pend_nz;
  logic ovf;

  // Same condition that moves the FSM into RREF.
  assign ref_issue = (state_q == S_RWAIT_RP) && (cnt_q == '0);

  sdram_refresh_timer #(
    .REF_INTERVAL(REF_INTERVAL)
  ) u_timer (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .run_i     (done_q),
    .issue_i   (ref_issue),
    .pend_nz_o (pend_nz),
    .overflow_o(ovf)
  );

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_PWRUP;
      cnt_q   <= '0;
      iref_q  <= '0;
      cke_q   <= 1'b0;
      cmd_q   <= CMD_INHIBIT;
      addr_q  <= '0;
      ba_q    <= '0;
      own_q   <= 1'b1;
      done_q  <= 1'b0;
      req_q   <= 1'b0;
      rdone_q <= 1'b0;
    end else begin
      cmd_q   <= CMD_NOP;
      addr_q  <= '0;
      ba_q    <= '0;
      rdone_q <= 1'b0;
      req_q   <= 1'b0;
      unique case (state_q)
        S_PWRUP: begin
          cke_q <= 1'b1;
          if (cnt_q == PWRUP_LIM) begin
            state_q <= S_PRE;
            cmd_q   <= CMD_PRE;
            addr_q  <= pre_all_addr();
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_PRE: begin
          state_q <= S_WAIT_RP;
          cnt_q   <= RP_LD;
        end
        S_WAIT_RP: begin
          if (cnt_q == '0) begin
            state_q <= S_IREF;
            cmd_q   <= CMD_REF;
            iref_q  <= iref_q + 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_IREF: begin
          state_q <= S_WAIT_RFC;
          cnt_q   <= RFC_LD;
        end
        S_WAIT_RFC: begin
          if (cnt_q == '0) begin
            if (iref_q == IREF_N) begin
              state_q <= S_MRS;
              cmd_q   <= CMD_MRS;
              addr_q  <= MODE_REG;
            end else begin
              state_q <= S_IREF;
              cmd_q   <= CMD_REF;
              iref_q  <= iref_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_MRS: begin
          state_q <= S_WAIT_MRD;
          cnt_q   <= MRD_LD;
        end
        S_WAIT_MRD: begin
          if (cnt_q == '0) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
            own_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_IDLE: begin
          if (req_q && ref_ack) begin
            state_q <= S_RPRE;
            cmd_q   <= CMD_PRE;
            addr_q  <= pre_all_addr();
            own_q   <= 1'b1;
          end else begin
            req_q <= pend_nz;
          end
        end
        S_RPRE: begin
          state_q <= S_RWAIT_RP;
          cnt_q   <= RP_LD;
        end
        S_RWAIT_RP: begin
          if (cnt_q == '0) begin
            state_q <= S_RREF;
            cmd_q   <= CMD_REF;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_RREF: begin
          state_q <= S_RWAIT_RFC;
          cnt_q   <= RFC_LD;
        end
        S_RWAIT_RFC: begin
          if (cnt_q == '0) begin
            state_q <= S_IDLE;
            rdone_q <= 1'b1;
            own_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= S_PWRUP;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign sdr_cke      = cke_q;
  assign sdr_cmd      = cmd_q;
  assign sdr_addr     = addr_q;
  assign sdr_ba       = ba_q;
  assign bus_own      = own_q;
  assign init_done    = done_q;
  assign ref_req      = req_q;
  assign ref_done     = rdone_q;
  assign ref_overflow = ovf;

endmodule
